// File: rtl/bpsk_frame_scheduler.sv
// bpsk_frame_scheduler: buffers UART bytes and emits framed bursts
// (preamble, sync, length, payload, optional checksum) to the modulator.
// Optional feature macro: FRAME_CHECKSUM_EN appends an 8-bit sum byte.
module bpsk_frame_scheduler #(
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned PREAMBLE_LEN = 4,
    parameter logic [7:0]  SYNC_BYTE    = 8'hD3,
    parameter int unsigned IDLE_TIMEOUT = 1000
) (
    input  logic       sysclk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       sleep,
    output logic       busy,
    output logic       overflow
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned TW = $clog2(IDLE_TIMEOUT + 1);
    localparam int unsigned IW = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_SYNC,
        S_LEN,
        S_PAY
`ifdef FRAME_CHECKSUM_EN
        , S_CSUM
`endif
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic [7:0]      r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW-1:0]   w_rd_nxt;
    logic [CW-1:0]   r_count;
    logic [TW-1:0]   r_timer;
    logic [CW-1:0]   r_frame_len;
    logic [CW-1:0]   w_frame_len;
    logic [IW-1:0]   r_idx;
    logic [IW-1:0]   w_idx;
    logic [7:0]      r_out_data;
    logic [7:0]      w_out_data;
    logic            r_out_valid;
    logic            w_out_valid;
    logic            w_push;
    logic            w_pop;
    logic            w_hs;
    logic            w_trigger;
`ifdef FRAME_CHECKSUM_EN
    logic [7:0]      r_csum;
    logic [7:0]      w_csum;
`endif

    assign in_ready  = (r_count != CW'(DEPTH));
    assign overflow  = in_valid && !in_ready;
    assign w_push    = in_valid && in_ready;
    assign w_hs      = r_out_valid && out_ready;
    assign w_rd_nxt  = r_rd_ptr + AW'(1);
    assign w_trigger = (r_state == S_IDLE) &&
                       ((r_count == CW'(DEPTH)) ||
                        ((r_count != '0) && (r_timer == TW'(IDLE_TIMEOUT))));
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign sleep     = (r_state == S_IDLE) && (r_count == '0);
    assign busy      = (r_state != S_IDLE);

    // Next-state and next output byte; a field advances only on a handshake
    always_comb begin
        w_next_state = r_state;
        w_out_data   = r_out_data;
        w_out_valid  = r_out_valid;
        w_idx        = r_idx;
        w_frame_len  = r_frame_len;
        w_pop        = 1'b0;
`ifdef FRAME_CHECKSUM_EN
        w_csum       = r_csum;
`endif
        case (r_state)
            S_IDLE: begin
                w_out_valid = 1'b0;
                if (w_trigger) begin
                    w_next_state = S_PRE;
                    w_frame_len  = r_count;
                    w_idx        = IW'(1);
                    w_out_valid  = 1'b1;
                    w_out_data   = 8'h55;
`ifdef FRAME_CHECKSUM_EN
                    w_csum       = 8'h00;
`endif
                end
            end
            S_PRE: begin
                if (w_hs) begin
                    if (r_idx == IW'(PREAMBLE_LEN)) begin
                        w_next_state = S_SYNC;
                        w_out_data   = SYNC_BYTE;
                    end else begin
                        w_idx      = r_idx + IW'(1);
                        w_out_data = 8'h55;
                    end
                end
            end
            S_SYNC: begin
                if (w_hs) begin
                    w_next_state = S_LEN;
                    w_out_data   = 8'(r_frame_len);
                end
            end
            S_LEN: begin
                if (w_hs) begin
                    w_next_state = S_PAY;
                    w_out_data   = r_mem[r_rd_ptr];
                    w_idx        = IW'(1);
`ifdef FRAME_CHECKSUM_EN
                    w_csum       = r_csum + 8'(r_frame_len);
`endif
                end
            end
            S_PAY: begin
                if (w_hs) begin
                    w_pop = 1'b1;
`ifdef FRAME_CHECKSUM_EN
                    w_csum = r_csum + r_out_data;
`endif
                    if (r_idx == IW'(r_frame_len)) begin
`ifdef FRAME_CHECKSUM_EN
                        w_next_state = S_CSUM;
                        w_out_data   = r_csum + r_out_data;
`else
                        w_next_state = S_IDLE;
                        w_out_valid  = 1'b0;
`endif
                    end else begin
                        w_idx      = r_idx + IW'(1);
                        w_out_data = r_mem[w_rd_nxt];
                    end
                end
            end
`ifdef FRAME_CHECKSUM_EN
            S_CSUM: begin
                if (w_hs) begin
                    w_next_state = S_IDLE;
                    w_out_valid  = 1'b0;
                end
            end
`endif
            default: begin
                w_next_state = S_IDLE;
                w_out_valid  = 1'b0;
            end
        endcase
    end

    // State, FIFO pointers, idle timer and registered output stage
    always_ff @(posedge sysclk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_timer     <= '0;
            r_frame_len <= '0;
            r_idx       <= '0;
            r_out_data  <= 8'h00;
            r_out_valid <= 1'b0;
`ifdef FRAME_CHECKSUM_EN
            r_csum      <= 8'h00;
`endif
        end else begin
            r_state     <= w_next_state;
            r_frame_len <= w_frame_len;
            r_idx       <= w_idx;
            r_out_data  <= w_out_data;
            r_out_valid <= w_out_valid;
`ifdef FRAME_CHECKSUM_EN
            r_csum      <= w_csum;
`endif
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= w_rd_nxt;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (w_push || (r_count == '0)) begin
                r_timer <= '0;
            end else if (r_timer != TW'(IDLE_TIMEOUT)) begin
                r_timer <= r_timer + TW'(1);
            end
        end
    end

    // Payload storage; contents are don't-care once pointers reset
    always_ff @(posedge sysclk) begin
        if (w_push) r_mem[r_wr_ptr] <= in_data;
    end

endmodule

// File: tb/tb_bpsk_frame_scheduler.sv
// Directed self-checking bench for bpsk_frame_scheduler (IDLE_TIMEOUT=20).
// Works with or without FRAME_CHECKSUM_EN defined.
module tb_bpsk_frame_scheduler;

    localparam int unsigned TMO = 20;
    localparam int unsigned PRE = 4;

    logic       sysclk = 1'b0;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       sleep;
    logic       busy;
    logic       overflow;

    int n_chk  = 0;
    int n_pass = 0;

    logic [7:0] rx_q  [$];
    logic [7:0] exp_q [$];
    int         ovf_cnt   = 0;
    int         stab_viol = 0;
    logic       stall_prev = 1'b0;
    logic [7:0] stall_data = 8'h00;

    bpsk_frame_scheduler #(
        .DEPTH        (16),
        .PREAMBLE_LEN (PRE),
        .SYNC_BYTE    (8'hD3),
        .IDLE_TIMEOUT (TMO)
    ) dut (
        .sysclk    (sysclk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sleep     (sleep),
        .busy      (busy),
        .overflow  (overflow)
    );

    always #5 sysclk = ~sysclk;

    // Capture handshakes, overflow pulses and output stability under stall
    always @(posedge sysclk) begin
        if (rst) begin
            stall_prev <= 1'b0;
        end else begin
            if (stall_prev && (!out_valid || out_data != stall_data))
                stab_viol <= stab_viol + 1;
            if (out_valid && out_ready) rx_q.push_back(out_data);
            if (overflow) ovf_cnt <= ovf_cnt + 1;
            stall_prev <= out_valid && !out_ready;
            stall_data <= out_data;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic push(input logic [7:0] d);
        in_valid = 1'b1;
        in_data  = d;
        @(negedge sysclk);
        in_valid = 1'b0;
    endtask

    // Append one expected frame with consecutive payload bytes
    task automatic add_frame(input int n, input logic [7:0] first);
        logic [7:0] sum;
        for (int i = 0; i < PRE; i++) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD3);
        exp_q.push_back(8'(n));
        sum = 8'(n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(first + 8'(i));
            sum = sum + first + 8'(i);
        end
`ifdef FRAME_CHECKSUM_EN
        exp_q.push_back(sum);
`endif
    endtask

    // Edges from the last push until out_valid is first seen
    task automatic latency(input string tag);
        int k;
        k = 0;
        while (k < 100) begin
            @(posedge sysclk);
            #1;
            k++;
            if (out_valid) break;
        end
        chk(tag, k, TMO + 1);
        @(negedge sysclk);
    endtask

    task automatic wait_q(input string tag, input int target, input bit rnd);
        int k;
        k = 0;
        while (rx_q.size() < target && k < 400) begin
            @(negedge sysclk);
            if (rnd) out_ready = 1'($urandom_range(0, 1));
            k++;
        end
        chk(tag, rx_q.size(), target);
    endtask

    task automatic wait_byte(input string tag, input logic [7:0] b);
        int k;
        k = 0;
        while (!(out_valid && out_data == b) && k < 200) begin
            @(negedge sysclk);
            k++;
        end
        chk(tag, 32'(out_valid && out_data == b), 1);
    endtask

    task automatic cmp_stream(input string tag, input int base);
        chk({tag, "_len"}, rx_q.size() - base, exp_q.size());
        foreach (exp_q[i])
            if (base + i < rx_q.size()) chk(tag, rx_q[base + i], exp_q[i]);
    endtask

    initial begin
        int base;
        int ovf0;
        int seen;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b1;
        repeat (3) @(negedge sysclk);
        rst = 1'b0;
        @(negedge sysclk);

        // Reset state
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 8'h00);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_sleep", sleep, 1);
        chk("rst_busy", busy, 0);
        chk("rst_overflow", overflow, 0);

        // Partial buffer sent on timeout
        base = rx_q.size();
        exp_q.delete();
        add_frame(3, 8'h01);
        push(8'h01);
        chk("t1_sleep_after_push", sleep, 0);
        push(8'h02);
        push(8'h03);
        latency("t1_latency");
        wait_q("t1_done", base + exp_q.size(), 1'b0);
        chk("t1_sleep_end", sleep, 1);
        chk("t1_busy_end", busy, 0);
        chk("t1_valid_end", out_valid, 0);
        cmp_stream("t1_byte", base);
`ifdef FRAME_CHECKSUM_EN
        chk("t1_csum", rx_q[rx_q.size() - 1], 8'h09);
`endif

        // Full buffer triggers without waiting for timeout
        repeat (3) @(negedge sysclk);
        base = rx_q.size();
        exp_q.delete();
        add_frame(16, 8'h00);
        for (int i = 0; i < 16; i++) push(8'(i));
        chk("t2_in_ready_full", in_ready, 0);
        chk("t2_busy_trig", busy, 0);
        @(negedge sysclk);
        chk("t2_busy_next", busy, 1);
        chk("t2_valid_next", out_valid, 1);
        chk("t2_first_55", out_data, 8'h55);
        wait_q("t2_done", base + exp_q.size(), 1'b0);
        cmp_stream("t2_byte", base);
        chk("t2_len_byte", rx_q[base + PRE + 1], 8'h10);
`ifdef FRAME_CHECKSUM_EN
        chk("t2_csum", rx_q[rx_q.size() - 1], 8'h88);
`endif

        // Random backpressure on a 5-byte frame
        repeat (3) @(negedge sysclk);
        base = rx_q.size();
        exp_q.delete();
        add_frame(5, 8'hA0);
        for (int i = 0; i < 5; i++) push(8'hA0 + 8'(i));
        latency("t3_latency");
        wait_q("t3_done", base + exp_q.size(), 1'b1);
        out_ready = 1'b1;
        cmp_stream("t3_byte", base);

        // Overflow while stalled, then a push during payload
        repeat (3) @(negedge sysclk);
        base = rx_q.size();
        ovf0 = ovf_cnt;
        exp_q.delete();
        add_frame(16, 8'h20);
        add_frame(1, 8'hEE);
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) push(8'h20 + 8'(i));
        push(8'hF0);
        push(8'hF1);
        chk("t4_ovf_pulses", ovf_cnt - ovf0, 2);
        chk("t4_in_ready", in_ready, 0);
        chk("t4_stalled_valid", out_valid, 1);
        out_ready = 1'b1;
        wait_byte("t4_saw_21", 8'h21);
        push(8'hEE);
        wait_q("t4_done", base + exp_q.size(), 1'b0);
        cmp_stream("t4_byte", base);
        chk("t4_ovf_total", ovf_cnt - ovf0, 2);

        // Reset during SYNC
        repeat (3) @(negedge sysclk);
        push(8'h40);
        push(8'h41);
        push(8'h42);
        wait_byte("t5_saw_sync", 8'hD3);
        rst = 1'b1;
        @(negedge sysclk);
        rst = 1'b0;
        chk("t5_valid", out_valid, 0);
        chk("t5_sleep", sleep, 1);
        chk("t5_in_ready", in_ready, 1);
        chk("t5_busy", busy, 0);
        base = rx_q.size();
        seen = 0;
        repeat (40) begin
            @(negedge sysclk);
            if (out_valid) seen++;
        end
        chk("t5_quiet", seen, 0);
        chk("t5_no_hs", rx_q.size(), base);
        exp_q.delete();
        add_frame(1, 8'h77);
        push(8'h77);
        latency("t5_latency");
        wait_q("t5_done", base + exp_q.size(), 1'b0);
        cmp_stream("t5_byte", base);

        chk("stable_under_stall", stab_viol, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/bpsk_frame_scheduler.md
# bpsk_frame_scheduler

Sequences the BPSK transmitter's byte stream. It buffers UART-received bytes and decides when to send a frame, either when the buffer is full or after an idle timeout. It then emits a framed byte stream (preamble, sync, length, payload, optional checksum) to the modulator over a valid/ready handshake. While idle it drives `sleep`, so the modulator can power down between bursts. It sits between the UART receiver and the modulator inside `transmitter`.

## Interface
- `DEPTH`, 16: payload buffer depth in bytes. Power of two, 2..128.
- `PREAMBLE_LEN`, 4: number of 8'h55 preamble bytes per frame, 1..15.
- `SYNC_BYTE`, 8'hD3: sync word sent after the preamble.
- `IDLE_TIMEOUT`, 1000: cycles without a new input byte before a partial buffer is sent; ≥1.
- `sysclk` input 1: system clock; all logic on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_data` input 8: byte from the UART receiver.
- `in_valid` input 1: `in_data` is valid.
- `in_ready` output 1: the buffer can accept a byte this cycle.
- `out_data` output 8: framed byte to the modulator.
- `out_valid` output 1: `out_data` is valid.
- `out_ready` input 1: the modulator accepts `out_data` this cycle.
- `sleep` output 1: no frame is in progress and the buffer is empty.
- `busy` output 1: a frame is in progress (state ≠ IDLE).
- `overflow` output 1: one-cycle pulse when `in_valid` is high while `in_ready` is low; the byte is dropped.

## Operation
- **Buffer:** circular FIFO of `DEPTH` bytes with a count of width `$clog2(DEPTH)+1`.
  - Push when `in_valid && in_ready`.
  - Pop on each payload handshake.
  - `in_ready = (count != DEPTH)`.
  - Push and pop in the same cycle leave the count unchanged.
- **Idle timer:**
  - Cleared on every accepted push and while count == 0.
  - Otherwise increments each cycle and saturates at `IDLE_TIMEOUT`.
- **Trigger** (evaluated only in IDLE): count == DEPTH, or (count > 0 and timer == `IDLE_TIMEOUT`).
- **On trigger:**
  - Latch `frame_len` = count.
  - Clear the checksum accumulator.
  - Go to PREAMBLE.
  - Bytes pushed during a frame stay in the FIFO for the next frame.
- **States** (each byte advances only on `out_valid && out_ready`):
  - IDLE: `out_valid` = 0.
  - PREAMBLE: send 8'h55 `PREAMBLE_LEN` times, then go to SYNC.
  - SYNC: send `SYNC_BYTE`, then go to LEN.
  - LEN: send `frame_len`, add it to the checksum, then go to PAYLOAD.
  - PAYLOAD: send the FIFO head `frame_len` times, adding each byte to the checksum.
    - Then go to CSUM if `FRAME_CHECKSUM_EN` is defined, else IDLE.
  - CSUM: send the checksum, then go to IDLE.
- **Checksum:** 8-bit sum modulo 256 of the length byte and all payload bytes. Carry is discarded.
- `out_data` and `out_valid` are registered. `out_data` holds stable while `out_valid && !out_ready`.
- `sleep = (state == IDLE) && (count == 0)`; `busy = (state != IDLE)`.

## Timing
- **Reset values:**
  - `out_valid` = 0, `out_data` = 8'h00.
  - `in_ready` = 1, `sleep` = 1, `busy` = 0, `overflow` = 0.
  - FIFO is empty, the timer is 0, and the state is IDLE.
- **Frame start:** trigger detected at cycle N means state = PREAMBLE and `out_valid` = 1 with 8'h55 at cycle N+1.
- **Throughput:** one byte per cycle while `out_ready` is held high, with no bubbles between fields.
- **Frame length:**
  - Without checksum, a frame is `PREAMBLE_LEN + 2 + frame_len` handshakes.
  - With `FRAME_CHECKSUM_EN` defined, add one handshake.
- **Inter-frame gap:** after the last handshake, `out_valid` is low for at least one cycle (the IDLE cycle). The earliest next PREAMBLE byte is two cycles after the last handshake.
- **Timeout:** with the last push at cycle P and no further input, the trigger is at cycle P+`IDLE_TIMEOUT`. The first byte appears at P+`IDLE_TIMEOUT`+1.
- **Backpressure:** `out_ready` low stalls the state machine indefinitely. No byte is lost or duplicated.
- **Mid-frame reset:** `rst` asserted in any state gives reset values on the next edge; FIFO contents are discarded.
- **Full buffer:** when full and `in_valid` is high, `overflow` pulses that same cycle, combinationally. Nothing is pushed.

## Configuration
- `FRAME_CHECKSUM_EN` defined: the CSUM state exists and each frame ends with the 8-bit checksum byte.
- `FRAME_CHECKSUM_EN` undefined: no CSUM state and no accumulator logic. The frame ends after the last payload byte.

## Test plan
- **Partial buffer, timeout:** push 8'h01, 8'h02, 8'h03 back-to-back, `out_ready`=1, `IDLE_TIMEOUT`=20.
  - First 8'h55 appears exactly 21 cycles after the last push.
  - Stream is 55 55 55 55 D3 03 01 02 03, plus checksum 8'h09 if `FRAME_CHECKSUM_EN`.
- **Full buffer:** push 16 bytes 8'h00..8'h0F continuously.
  - Trigger fires on the cycle count reaches 16, without waiting for the timeout.
  - Length byte is 8'h10; checksum is 8'h88.
- **Backpressure:** toggle `out_ready` randomly, low 50% of cycles, during a 5-byte frame.
  - Output sequence is identical to the unstalled case.
  - `out_data` never changes while `out_valid && !out_ready`.
- **Overflow and mid-frame push:** fill 16 bytes with `out_ready`=0, then drive 2 more with `in_valid`.
  - `overflow` pulses twice; the frame length is still 16.
  - A byte pushed during PAYLOAD is sent in the following frame.
- **Reset mid-frame:** assert `rst` for one cycle during SYNC.
  - Next cycle: `out_valid`=0, `sleep`=1, `in_ready`=1.
  - No further output until new input plus timeout.
- **Sleep:** `sleep` is 1 after reset, 0 from the first push, and returns to 1 one cycle after the final handshake when the FIFO is empty.
